// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic plus an iterative shift-add unsigned multiply.
// Optional macro ALU_MC_EARLY_EN ends the multiply as soon as the remaining multiplier is zero.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [2*WIDTH-1:0]   mcand_r, mcand_s;
  logic [2*WIDTH-1:0]   acc_r, acc_s, acc_add_s;
  logic [WIDTH-1:0]     mplier_r, mplier_s, mshift_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [WIDTH-1:0]     result_r, result_s;
  logic [WIDTH-1:0]     result_hi_r, result_hi_s;
  logic                 overflow_r, overflow_s;
  logic                 done_r, done_s;
  logic [WIDTH-1:0]     alu_s;
  logic                 alu_ovf_s;
  logic                 last_s;

  // Signed overflow of a+b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  assign mshift_s  = mplier_r >> 1;
  assign acc_add_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

`ifdef ALU_MC_EARLY_EN
  assign last_s = (cnt_r == CW'(WIDTH - 1)) || (mshift_s == {WIDTH{1'b0}});
`else
  assign last_s = (cnt_r == CW'(WIDTH - 1));
`endif

  // Single-cycle operation datapath.
  always_comb begin
    alu_s     = {WIDTH{1'b0}};
    alu_ovf_s = 1'b0;
    case (op)
      3'b000: begin
        alu_s     = a + b;
        alu_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], alu_s[WIDTH-1]);
      end
      3'b001: begin
        alu_s     = a - b;
        alu_ovf_s = sub_ovf(a[WIDTH-1], b[WIDTH-1], alu_s[WIDTH-1]);
      end
      3'b010:  alu_s = a & b;
      3'b011:  alu_s = a | b;
      3'b100:  alu_s = a ^ b;
      3'b101:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110:  alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and output-register update logic.
  always_comb begin
    state_s     = state_r;
    mcand_s     = mcand_r;
    acc_s       = acc_r;
    mplier_s    = mplier_r;
    cnt_s       = cnt_r;
    result_s    = result_r;
    result_hi_s = result_hi_r;
    overflow_s  = overflow_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (op == 3'b111) begin
            mcand_s  = {{WIDTH{1'b0}}, a};
            mplier_s = b;
            acc_s    = {(2*WIDTH){1'b0}};
            cnt_s    = {CW{1'b0}};
            state_s  = MUL;
          end else begin
            result_s    = alu_s;
            result_hi_s = {WIDTH{1'b0}};
            overflow_s  = alu_ovf_s;
            done_s      = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        acc_s    = acc_add_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mshift_s;
        cnt_s    = cnt_r + CW'(1);
        if (last_s) begin
          result_s    = acc_add_s[WIDTH-1:0];
          result_hi_s = acc_add_s[2*WIDTH-1:WIDTH];
          overflow_s  = 1'b0;
          done_s      = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = MUL;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      mcand_r     <= {(2*WIDTH){1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mcand_r     <= mcand_s;
      acc_r       <= acc_s;
      mplier_r    <= mplier_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      result_hi_r <= result_hi_s;
      overflow_r  <= overflow_s;
      done_r      <= done_s;
    end
  end

  assign busy      = (state_r == MUL);
  assign done      = done_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign overflow  = overflow_r;
  assign zero      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=8.
// Multiply latencies follow ALU_MC_EARLY_EN when it is defined for the build.
module tb_alu_mc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = 8'h00;
  logic [W-1:0] b = 8'h00;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result, result_hi;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Present a request for one cycle; returns in the cycle after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, result, result_hi, overflow, zero} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b res=%h hi=%h ovf=%b zero=%b want 0 0 00 00 0 1",
               busy, done, result, result_hi, overflow, zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_add;
    issue(3'b000, 8'h7F, 8'h01);
    checks++;
    if ({done, result, overflow, zero, result_hi} !== {1'b1, 8'h80, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL add_ovf: done=%b res=%h ovf=%b zero=%b hi=%h want 1 80 1 0 00",
               done, result, overflow, zero, result_hi);
    end
    @(negedge clk);
    checks++;
    if ({done, result} !== {1'b0, 8'h80}) begin
      errors++;
      $display("FAIL add_hold: done=%b res=%h want 0 80", done, result);
    end
  endtask

  task automatic test_sub;
    issue(3'b001, 8'h05, 8'h05);
    checks++;
    if ({done, result, zero, overflow} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_zero: done=%b res=%h zero=%b ovf=%b want 1 00 1 0", done, result, zero, overflow);
    end
    issue(3'b001, 8'h80, 8'h01);
    checks++;
    if ({result, overflow} !== {8'h7F, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf: res=%h ovf=%b want 7f 1", result, overflow);
    end
  endtask

  task automatic test_logic_cmp;
    logic [2:0]   ops [8] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b101, 3'b110, 3'b000};
    logic [W-1:0] va  [8] = '{8'hCA, 8'hCA, 8'hCA, 8'hFF, 8'hFF, 8'h01, 8'h01, 8'hFF};
    logic [W-1:0] vb  [8] = '{8'h0F, 8'h0F, 8'h0F, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h01};
    logic [W-1:0] exp [8] = '{8'h0A, 8'hCF, 8'hC5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    logic         eov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], va[i], vb[i]);
      checks++;
      if ({done, result, overflow, zero} !== {1'b1, exp[i], eov[i], (exp[i] == 8'h00)}) begin
        errors++;
        $display("FAIL logic_cmp[%0d] op=%b: done=%b res=%h ovf=%b zero=%b want 1 %h %b",
                 i, ops[i], done, result, overflow, zero, exp[i], eov[i]);
      end
    end
  endtask

  // Runs one MULTU, counting busy cycles and poking a start mid-multiply.
  task automatic run_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                         input int exp_busy, input logic [2*W-1:0] exp_prod, input string name);
    int n = 0;
    logic overlap = 1'b0;
    issue(3'b111, x, y);
    while (busy === 1'b1 && n < 40) begin
      if (done === 1'b1) overlap = 1'b1;
      start = (n == 1) ? 1'b1 : 1'b0;
      op = 3'b000; a = 8'h01; b = 8'h01;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== exp_busy || overlap !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: cycles=%0d overlap=%b want %0d 0", name, n, overlap, exp_busy);
    end
    checks++;
    if ({done, result_hi, result, overflow} !== {1'b1, exp_prod, 1'b0}) begin
      errors++;
      $display("FAIL %s_prod: done=%b prod=%h ovf=%b want 1 %h 0", name, done, {result_hi, result}, overflow, exp_prod);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, result_hi, result} !== {1'b0, 1'b0, exp_prod}) begin
      errors++;
      $display("FAIL %s_noqueue: done=%b busy=%b prod=%h want 0 0 %h", name, done, busy, {result_hi, result}, exp_prod);
    end
  endtask

  task automatic test_mul;
`ifdef ALU_MC_EARLY_EN
    run_mul(8'hFF, 8'hFF, 8, 16'hFE01, "mul_ff");
    run_mul(8'h0A, 8'h03, 2, 16'h001E, "mul_early3");
    run_mul(8'h5A, 8'h00, 1, 16'h0000, "mul_early0");
`else
    run_mul(8'hFF, 8'hFF, 8, 16'hFE01, "mul_ff");
    run_mul(8'h0A, 8'h03, 8, 16'h001E, "mul_small");
    run_mul(8'h5A, 8'h00, 8, 16'h0000, "mul_zero");
`endif
  endtask

  task automatic test_reset_mid_mul;
    logic saw_done = 1'b0;
    issue(3'b111, 8'h12, 8'hF4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, result, result_hi, zero, overflow} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mul: busy=%b done=%b res=%h hi=%h zero=%b ovf=%b want 0 0 00 00 1 0",
               busy, done, result, result_hi, zero, overflow);
    end
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mul_discard: stray done/busy seen=%b want 0", saw_done);
    end
    issue(3'b000, 8'h02, 8'h03);
    checks++;
    if ({done, result, zero} !== {1'b1, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL reset_then_add: done=%b res=%h zero=%b want 1 05 0", done, result, zero);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    issue(3'b111, 8'h03, 8'h05);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({done, result_hi, result} !== {1'b1, 16'h000F}) begin
      errors++;
      $display("FAIL b2b_mul: done=%b prod=%h want 1 000f", done, {result_hi, result});
    end
    start = 1'b1; op = 3'b010; a = 8'hF0; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, result, result_hi} !== {1'b1, 1'b0, 8'h30, 8'h00}) begin
      errors++;
      $display("FAIL b2b_and: done=%b busy=%b res=%h hi=%h want 1 0 30 00", done, busy, result, result_hi);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_pulse: done=%b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_cmp();
    test_mul();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
